// File: rtl/data_ram_be_if.sv
// Request/response bus between the load/store unit and data_ram_be.
// Master drives the request, slave returns data, valid, ready and error.
interface data_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) ();
    logic                CS;
    logic                R_W;
    logic [ADDR_W-1:0]   Addr;
    logic [DATA_W-1:0]   WData;
    logic [DATA_W/8-1:0] BE;
    logic [DATA_W-1:0]   RData;
    logic                RValid;
    logic                Ready;
    logic                Err;

    modport master (
        output CS, R_W, Addr, WData, BE,
        input  RData, RValid, Ready, Err
    );

    modport slave (
        input  CS, R_W, Addr, WData, BE,
        output RData, RValid, Ready, Err
    );
endinterface

// File: rtl/data_ram_be.sv
// Single-port data RAM with byte enables, registered read, range check.
// Optional reset-time clear engine: define RAM_INIT_CLEAR_EN.
module data_ram_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic         CLK,
    input  logic         Rst,
    data_ram_be_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic ready;
    logic acc;
    logic in_rng;
    logic wr_ok;
    logic rd_ok;
    logic clr_we;

    logic rvalid_q, rvalid_d;
    logic err_q, err_d;
    logic zero_q, zero_d;

    assign acc    = bus.CS && ready;
    assign in_rng = {1'b0, bus.Addr} < DEPTH_L;
    assign wr_ok  = acc && bus.R_W && in_rng;
    assign rd_ok  = acc && !bus.R_W && in_rng;

`ifdef RAM_INIT_CLEAR_EN
    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;

    // Clear engine: walk every word once, then settle in IDLE.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        clr_we  = 1'b0;
        if (state_q == S_CLEAR) begin
            clr_we = !Rst;
            clr_d  = clr_q + 1'b1;
            if (clr_q == LAST) begin
                state_d = S_IDLE;
                clr_d   = '0;
            end
        end
    end

    // FSM state and clear pointer; reset restarts clearing at word 0.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    assign ready = (state_q == S_IDLE) && !Rst;
`else
    logic ready_q, ready_d;

    assign ready_d = 1'b1;
    assign clr_we  = 1'b0;

    // Without the clear engine the RAM is ready as soon as reset drops.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q && !Rst;
`endif

    // Response flags; zero_q forces RData to 0 after reset or a bad read.
    always_comb begin
        rvalid_d = acc && !bus.R_W;
        err_d    = acc && !in_rng;
        zero_d   = zero_q;
        if (rd_ok) begin
            zero_d = 1'b0;
        end else if (acc && !bus.R_W) begin
            zero_d = 1'b1;
        end
    end

    // Response registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

    // RAM array: clear or byte-lane write, plus registered read.
    always_ff @(posedge CLK) begin
`ifdef RAM_INIT_CLEAR_EN
        if (clr_we) begin
            mem[clr_q] <= '0;
        end else
`endif
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.BE[i]) begin
                    mem[bus.Addr][8*i +: 8] <= bus.WData[8*i +: 8];
                end
            end
        end
        if (rd_ok) begin
            ram_q <= mem[bus.Addr];
        end
    end

    assign bus.RData  = zero_q ? '0 : ram_q;
    assign bus.RValid = rvalid_q;
    assign bus.Ready  = ready;
    assign bus.Err    = err_q;
endmodule

// File: tb/tb_data_ram_be.sv
// Directed testbench for data_ram_be (DEPTH=3000 to exercise range check).
// Build with or without RAM_INIT_CLEAR_EN.
module tb_data_ram_be;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int DP = 3000;

    logic CLK = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    data_ram_be_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_ram_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .CLK (CLK),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.CS    = 1'b0;
        bus.R_W   = 1'b0;
        bus.Addr  = '0;
        bus.WData = '0;
        bus.BE    = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        bus.CS = 1'b1; bus.R_W = 1'b1;
        bus.Addr = a; bus.WData = d; bus.BE = be;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.CS = 1'b1; bus.R_W = 1'b0;
        bus.Addr = a; bus.BE = 4'hF;
        tick();
    endtask

    task automatic wait_ready(input string tag);
        cnt = 0;
        while (!bus.Ready && cnt < DP + 20) begin
            tick();
            cnt++;
        end
`ifdef RAM_INIT_CLEAR_EN
        chk(tag, cnt, DP);
`else
        chk(tag, cnt, 0);
`endif
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        tick();
        chk("rst_rdata", bus.RData, 0);
        chk("rst_rvalid", 32'(bus.RValid), 0);
        chk("rst_err", 32'(bus.Err), 0);
        chk("rst_ready", 32'(bus.Ready), 0);
        Rst = 1'b0;
        #1;
        wait_ready("t1_ready_cycles");
        chk("t1_ready_high", 32'(bus.Ready), 1);

`ifdef RAM_INIT_CLEAR_EN
        rd(0);
        chk("t1_rd0_v", 32'(bus.RValid), 1);
        chk("t1_rd0_d", bus.RData, 0);
        rd(AW'(DP - 1));
        chk("t1_rdlast_v", 32'(bus.RValid), 1);
        chk("t1_rdlast_d", bus.RData, 0);
`endif

        wr(5, 32'hDEADBEEF, 4'hF);
        chk("t2_wr_norv", 32'(bus.RValid), 0);
        wr(5, 32'h000000AA, 4'b0001);
        rd(5);
        chk("t2_rv", 32'(bus.RValid), 1);
        chk("t2_rd", bus.RData, 32'hDEADBEAA);
        idle();
        tick();
        chk("t2_rv_pulse", 32'(bus.RValid), 0);
        chk("t2_hold", bus.RData, 32'hDEADBEAA);

        wr(5, 32'h12345678, 4'h0);
        rd(5);
        chk("t2_be0_noop", bus.RData, 32'hDEADBEAA);
        wr(5, 32'h99887766, 4'b1010);
        rd(5);
        chk("t2_be_a", bus.RData, 32'h99AD77AA);
        wr(5, 32'hDEADBEAA, 4'hF);

        wr(7, 32'h11111111, 4'hF);
        rd(7);
        chk("t3_raw_v", 32'(bus.RValid), 1);
        chk("t3_raw_d", bus.RData, 32'h11111111);

        wr(1, 32'hA1A1A1A1, 4'hF);
        wr(2, 32'hB2B2B2B2, 4'hF);
        wr(3, 32'hC3C3C3C3, 4'hF);
        rd(1);
        chk("t3_b2b1_v", 32'(bus.RValid), 1);
        chk("t3_b2b1_d", bus.RData, 32'hA1A1A1A1);
        rd(2);
        chk("t3_b2b2_v", 32'(bus.RValid), 1);
        chk("t3_b2b2_d", bus.RData, 32'hB2B2B2B2);
        rd(3);
        chk("t3_b2b3_v", 32'(bus.RValid), 1);
        chk("t3_b2b3_d", bus.RData, 32'hC3C3C3C3);

        wr(AW'(DP - 1), 32'h0BADF00D, 4'hF);
        chk("t4_edge_wr_err", 32'(bus.Err), 0);
        rd(AW'(DP - 1));
        chk("t4_edge_rd_err", 32'(bus.Err), 0);
        chk("t4_edge_rd_d", bus.RData, 32'h0BADF00D);

        wr(AW'(DP), 32'hFFFFFFFF, 4'hF);
        chk("t4_oor_wr_err", 32'(bus.Err), 1);
        chk("t4_oor_wr_rv", 32'(bus.RValid), 0);
        rd(AW'(DP));
        chk("t4_oor_rd_err", 32'(bus.Err), 1);
        chk("t4_oor_rd_rv", 32'(bus.RValid), 1);
        chk("t4_oor_rd_d", bus.RData, 0);
        idle();
        tick();
        chk("t4_err_pulse", 32'(bus.Err), 0);
        chk("t4_oor_hold0", bus.RData, 0);
        rd(AW'(DP - 1));
        chk("t4_keep_last", bus.RData, 32'h0BADF00D);
        rd(5);
        chk("t4_keep5", bus.RData, 32'hDEADBEAA);
        rd(1);
        chk("t4_keep1", bus.RData, 32'hA1A1A1A1);

        wr(9, 32'h00000005, 4'hF);
        bus.CS = 1'b1; bus.R_W = 1'b0; bus.Addr = 7;
        Rst = 1'b1;
        tick();
        chk("t5_rst_rv", 32'(bus.RValid), 0);
        chk("t5_rst_rd", bus.RData, 0);
        idle();
        Rst = 1'b0;
        #1;
`ifdef RAM_INIT_CLEAR_EN
        for (int i = 0; i < DP / 2; i++) tick();
        chk("t5_mid_ready", 32'(bus.Ready), 0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        wait_ready("t5_restart_cycles");
        rd(5);
        chk("t5_cleared5", bus.RData, 0);
        rd(AW'(DP - 1));
        chk("t5_cleared_last", bus.RData, 0);
`else
        chk("t6_ready_first", 32'(bus.Ready), 1);
        rd(9);
        chk("t6_keep9_v", 32'(bus.RValid), 1);
        chk("t6_keep9_d", bus.RData, 32'h00000005);
        rd(5);
        chk("t6_keep5", bus.RData, 32'hDEADBEAA);
`endif
        idle();
        tick();
        chk("end_rv", 32'(bus.RValid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
